// File: rtl/signal_measure_core.sv
// Two-channel measurement core: gated edge counts on both inputs, sig_in0->sig_in1
// rising-edge delay, and high/low time of sig_in1, all in sys_clk cycles.
module signal_measure_core #(
  parameter int unsigned GATE_CYCLES = 100_000_000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        sig_in0,
  input  logic        sig_in1,
  output logic [31:0] sig_freq_cnt_buf1,
  output logic [31:0] sig_freq_cnt_buf2,
  output logic [31:0] phase_diff_cnt_buf,
  output logic [31:0] sig_in_high_cnt_buf,
  output logic [31:0] sig_in_low_cnt_buf
);

  localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronisers and rise detection (index 0 = sig_in0, 1 = sig_in1)
  // ---------------------------------------------------------------------------
  logic [1:0] meta_q, sync_q, prev_q;
  logic       rise0, rise1, level1;

  // NOTE: every register in this block is cleared by the asynchronous reset and
  // updated with non-blocking assignments, so all flops sample the same pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {sig_in1, sig_in0};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise0  = sync_q[0] & ~prev_q[0];
  assign rise1  = sync_q[1] & ~prev_q[1];
  assign level1 = sync_q[1];

  // ---------------------------------------------------------------------------
  // Frequency: shared gate counter, per-channel edge counters
  // ---------------------------------------------------------------------------
  logic [GW-1:0] gate_q, gate_d;
  logic [31:0]   edge0_q, edge0_d, edge1_q, edge1_d;
  logic [31:0]   freq0_q, freq0_d, freq1_q, freq1_d;
  logic          gate_end;

  assign gate_end = (gate_q == GATE_LAST);

  // NOTE: each combinational block assigns every target a hold value first, so no
  // path through the if/else can leave a signal unassigned and infer a latch.
  always_comb begin
    gate_d  = gate_q + GW'(1);
    edge0_d = sat_inc(edge0_q, rise0);
    edge1_d = sat_inc(edge1_q, rise1);
    freq0_d = freq0_q;
    freq1_d = freq1_q;
    if (gate_end) begin
      gate_d  = '0;
      freq0_d = edge0_d;
      freq1_d = edge1_d;
      edge0_d = '0;
      edge1_d = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q  <= '0;
      edge0_q <= '0;
      edge1_q <= '0;
      freq0_q <= '0;
      freq1_q <= '0;
    end else begin
      gate_q  <= gate_d;
      edge0_q <= edge0_d;
      edge1_q <= edge1_d;
      freq0_q <= freq0_d;
      freq1_q <= freq1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Phase: cycles from a sig_in0 rise to the following sig_in1 rise
  // ---------------------------------------------------------------------------
  logic        armed_q, armed_d;
  logic [31:0] phase_cnt_q, phase_cnt_d;
  logic [31:0] phase_buf_q, phase_buf_d;

  always_comb begin
    armed_d     = armed_q;
    phase_cnt_d = phase_cnt_q;
    phase_buf_d = phase_buf_q;
    if (rise0 && rise1) begin
      phase_buf_d = '0;
      phase_cnt_d = '0;
      armed_d     = 1'b0;
    end else if (rise0) begin
      // A repeated reference edge restarts the measurement.
      phase_cnt_d = '0;
      armed_d     = 1'b1;
    end else if (rise1) begin
      if (armed_q) begin
        phase_buf_d = sat_inc(phase_cnt_q, 1'b1);
        armed_d     = 1'b0;
      end
    end else if (armed_q) begin
      phase_cnt_d = sat_inc(phase_cnt_q, 1'b1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b0;
      phase_cnt_q <= '0;
      phase_buf_q <= '0;
    end else begin
      armed_q     <= armed_d;
      phase_cnt_q <= phase_cnt_d;
      phase_buf_q <= phase_buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Duty: high/low time of sig_in1, latched per complete period
  // ---------------------------------------------------------------------------
  logic        primed_q, primed_d;
  logic [31:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [31:0] high_buf_q, high_buf_d, low_buf_q, low_buf_d;

  always_comb begin
    primed_d   = primed_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    high_buf_d = high_buf_q;
    low_buf_d  = low_buf_q;
    if (rise1) begin
      // The first rise after reset only starts a period; nothing complete to report.
      if (primed_q) begin
        high_buf_d = high_cnt_q;
        low_buf_d  = low_cnt_q;
      end
      high_cnt_d = 32'd1;
      low_cnt_d  = '0;
      primed_d   = 1'b1;
    end else if (level1) begin
      high_cnt_d = sat_inc(high_cnt_q, 1'b1);
    end else begin
      low_cnt_d  = sat_inc(low_cnt_q, 1'b1);
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      primed_q   <= 1'b0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      high_buf_q <= '0;
      low_buf_q  <= '0;
    end else begin
      primed_q   <= primed_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      high_buf_q <= high_buf_d;
      low_buf_q  <= low_buf_d;
    end
  end

  assign sig_freq_cnt_buf1   = freq0_q;
  assign sig_freq_cnt_buf2   = freq1_q;
  assign phase_diff_cnt_buf  = phase_buf_q;
  assign sig_in_high_cnt_buf = high_buf_q;
  assign sig_in_low_cnt_buf  = low_buf_q;

endmodule

// File: tb/tb_signal_measure_core.sv
// Directed bench for signal_measure_core with GATE_CYCLES=1000; inputs change on the
// falling edge and outputs are sampled there too.
module tb_signal_measure_core;

  localparam int unsigned GATE = 1000;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        sig_in0 = 1'b0;
  logic        sig_in1 = 1'b0;
  logic [31:0] freq0, freq1, phase, high_t, low_t;

  int n_vec = 0;
  int n_mis = 0;

  // Periodic waveform generator state used by step()
  int cnt     = 0;
  bit wave_en = 1'b0;
  int p0 = 10, h0 = 5, p1 = 20, h1 = 5, d1 = 0;

  signal_measure_core #(.GATE_CYCLES(GATE)) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .sig_in0             (sig_in0),
    .sig_in1             (sig_in1),
    .sig_freq_cnt_buf1   (freq0),
    .sig_freq_cnt_buf2   (freq1),
    .phase_diff_cnt_buf  (phase),
    .sig_in_high_cnt_buf (high_t),
    .sig_in_low_cnt_buf  (low_t)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      if (wave_en) begin
        sig_in0 = ((cnt % p0) < h0);
        sig_in1 = (((cnt + 10 * p1 - d1) % p1) < h1);
      end
      @(posedge sys_clk);
      @(negedge sys_clk);
      cnt++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and idle
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    step(20);
    check("rst_freq0", freq0, 32'd0);
    check("rst_freq1", freq1, 32'd0);
    check("rst_phase", phase, 32'd0);
    check("rst_high",  high_t, 32'd0);
    check("rst_low",   low_t,  32'd0);

    // Frequency and 5H/15L duty
    wave_en = 1'b1; cnt = 0;
    p0 = 10; h0 = 5; p1 = 20; h1 = 5; d1 = 0;
    step(2500);
    check("freq0_p10", freq0, 32'd100);
    check("freq1_p20", freq1, 32'd50);
    check("high_5",    high_t, 32'd5);
    check("low_15",    low_t,  32'd15);
    check("phase_coincident", phase, 32'd0);

    // Duty change to 12H/8L
    h1 = 12;
    step(100);
    check("high_12", high_t, 32'd12);
    check("low_8",   low_t,  32'd8);

    // sig_in1 = sig_in0 delayed 3 cycles, then aligned
    p1 = 10; h1 = 5; d1 = 3;
    step(50);
    check("phase_3", phase, 32'd3);
    d1 = 0;
    step(50);
    check("phase_0", phase, 32'd0);

    // Two reference rises 4 apart, then sig_in1 two cycles after the second
    wave_en = 1'b0; sig_in0 = 1'b0; sig_in1 = 1'b0;
    step(20);
    sig_in0 = 1'b1; step(2);
    sig_in0 = 1'b0; step(2);
    sig_in0 = 1'b1; step(2);
    sig_in1 = 1'b1; step(2);
    sig_in0 = 1'b0; step(5);
    sig_in1 = 1'b0; step(10);
    check("phase_restart_2", phase, 32'd2);
    // Lone sig_in1 rise: phase holds, duty reports 7 high / 10 low
    sig_in1 = 1'b1; step(3);
    sig_in1 = 1'b0; step(10);
    check("phase_unarmed_hold", phase, 32'd2);
    check("high_7",  high_t, 32'd7);
    check("low_10",  low_t,  32'd10);

    // Inputs stuck low
    step(2100);
    check("freq0_idle", freq0, 32'd0);
    check("freq1_idle", freq1, 32'd0);
    check("high_hold",  high_t, 32'd7);
    check("low_hold",   low_t,  32'd10);

    // Mid-window reset, then restart from scratch
    wave_en = 1'b1; cnt = 0;
    p0 = 10; h0 = 5; p1 = 20; h1 = 5; d1 = 0;
    step(1500);
    rst_n = 1'b0;
    #1;
    check("midrst_freq0", freq0, 32'd0);
    check("midrst_freq1", freq1, 32'd0);
    check("midrst_phase", phase, 32'd0);
    check("midrst_high",  high_t, 32'd0);
    check("midrst_low",   low_t,  32'd0);
    step(3);
    rst_n = 1'b1; cnt = 0;
    step(15);
    check("prime_only_high", high_t, 32'd0);
    check("prime_only_low",  low_t,  32'd0);
    step(15);
    check("first_latch_high", high_t, 32'd5);
    check("first_latch_low",  low_t,  32'd15);
    step(GATE - 31);
    check("pre_gate_freq0", freq0, 32'd0);
    check("pre_gate_freq1", freq1, 32'd0);
    step(1);
    check("gate_freq0", freq0, 32'd100);
    check("gate_freq1", freq1, 32'd50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
